// File: rtl/mem_subsystem_pkg.sv
// Shared definitions for the MAR/main-memory block: FSM encodings,
// default widths and the access-type enum.
package mem_subsystem_pkg;

  localparam int MAR_W      = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/mem_subsystem_ram_sp.sv
// Single-port synchronous RAM, registered read, no reset.
// Contents are undefined until written.
module ram_sp #(
  parameter int    ADDR_W    = 9,
  parameter int    DATA_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem_q[addr] <= din;
    dout <= mem_q[addr];
  end

endmodule

// File: rtl/mem_subsystem.sv
// MAR plus word-addressed main memory with a request/ready handshake.
// Define MEM_OOR_ERR_EN to flag and neutralise out-of-range accesses.
module mem_subsystem
  import mem_subsystem_pkg::*;
#(
  parameter int    ADDR_W      = 9,
  parameter int    DATA_W      = DATA_W_DEF,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              MARin,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic [DATA_W-1:0] MDRdata,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic [DATA_W-1:0] MDataIn,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic [MAR_W-1:0]  mar_q,
  output logic              mem_err
);

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oor_q, oor_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic              req;
  logic              oor_now;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;

  assign req = mem_rd | mem_wr;

`ifdef MEM_OOR_ERR_EN
  assign oor_now = |mar_q[MAR_W-1:ADDR_W];
`else
  assign oor_now = 1'b0;
`endif

  // In IDLE the RAM already looks at the MAR so a zero-wait read
  // has its data by the time ACCESS is reached.
  assign ram_addr = (state_q == S_IDLE) ? mar_q[ADDR_W-1:0] : addr_q;
  assign ram_we   = (state_q == S_ACCESS) && (op_q == OP_WR) && !oor_q;

  ram_sp #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wdata_q),
    .dout (ram_dout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oor_d   = oor_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d    = mem_rd ? OP_RD : OP_WR;
          addr_d  = mar_q[ADDR_W-1:0];
          wdata_d = MDRdata;
          oor_d   = oor_now;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else cnt_d = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d = S_DONE;
        ready_d = 1'b1;
        err_d   = oor_q;
        if (op_q == OP_RD) rdata_d = oor_q ? '0 : ram_dout;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mar_q   <= '0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (MARin) mar_q <= MAR_W'(BusMuxOut);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign MDataIn   = rdata_q;
  assign mem_ready = ready_q;
  assign mem_err   = err_q;
  assign mem_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_subsystem.sv
// Scoreboard bench for mem_subsystem (WAIT_STATES=1, ADDR_W=9).
// Expected completions are queued at issue and popped by a monitor.
module tb_mem_subsystem;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        MARin = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] BusMuxOut = '0;
  logic [31:0] MDRdata = '0;
  logic [31:0] MDataIn;
  logic [31:0] mar_q;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_err;

  mem_subsystem #(
    .ADDR_W     (9),
    .DATA_W     (32),
    .WAIT_STATES(1),
    .INIT_FILE  ("")
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .MARin    (MARin),
    .BusMuxOut(BusMuxOut),
    .MDRdata  (MDRdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .MDataIn  (MDataIn),
    .mem_ready(mem_ready),
    .mem_busy (mem_busy),
    .mar_q    (mar_q),
    .mem_err  (mem_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!clear && mem_ready) begin
      ready_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected mem_ready", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("mem_err at ready", {31'd0, mem_err}, {31'd0, e.err});
        if (e.rd) chk("read data", MDataIn, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_mar(input logic [31:0] a);
    BusMuxOut = a;
    MARin = 1'b1;
    tick();
    MARin = 1'b0;
  endtask

  task automatic req(input logic rd, input logic wr,
                     input logic [31:0] wd, input logic [31:0] exp_d,
                     input logic exp_e, input string name);
    exp_t e;
    int n;
    e.rd = rd;
    e.data = exp_d;
    e.err = exp_e;
    sbq.push_back(e);
    MDRdata = wd;
    mem_rd = rd;
    mem_wr = wr;
    tick();
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    n = 1;
    while (!mem_ready && n < 20) begin
      tick();
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'd3);
    tick();
  endtask

  initial begin
    exp_t e;
    int rc;
    int guard;

    #2;
    chk("reset MDataIn", MDataIn, 32'd0);
    chk("reset ready", {31'd0, mem_ready}, 32'd0);
    chk("reset busy", {31'd0, mem_busy}, 32'd0);
    chk("reset mar", mar_q, 32'd0);
    chk("reset err", {31'd0, mem_err}, 32'd0);
    tick();
    tick();
    #3 clear = 1'b0;
    tick();

    set_mar(32'h0000_0010);
    chk("mar load", mar_q, 32'h0000_0010);
    req(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, "write 0x10");
    req(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, "read 0x10");
    chk("MDataIn held", MDataIn, 32'hDEAD_BEEF);

    set_mar(32'h0000_0020);
    req(1'b0, 1'b1, 32'h0BAD_F00D, 32'h0, 1'b0, "write 0x20");

    set_mar(32'h0000_0010);
    e.rd = 1'b1;
    e.data = 32'hDEAD_BEEF;
    e.err = 1'b0;
    sbq.push_back(e);
    rc = ready_cnt;
    mem_rd = 1'b1;
    tick();
    chk("busy in wait", {31'd0, mem_busy}, 32'd1);
    BusMuxOut = 32'h0000_0020;
    MARin = 1'b1;
    tick();
    MARin = 1'b0;
    tick();
    mem_rd = 1'b0;
    repeat (5) tick();
    chk("single ready pulse", 32'(ready_cnt - rc), 32'd1);
    chk("mar after busy load", mar_q, 32'h0000_0020);

    set_mar(32'h0000_0010);
    req(1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, "rd+wr");
    req(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, "re-read 0x10");

    set_mar(32'h0000_0030);
    req(1'b0, 1'b1, 32'h55AA_55AA, 32'h0, 1'b0, "write old 0x30");
    req(1'b1, 1'b0, 32'h0, 32'h55AA_55AA, 1'b0, "read old 0x30");
    rc = ready_cnt;
    MDRdata = 32'hCAFE_F00D;
    mem_wr = 1'b1;
    tick();
    mem_wr = 1'b0;
    chk("busy before abort", {31'd0, mem_busy}, 32'd1);
    #2 clear = 1'b1;
    #1;
    chk("abort MDataIn", MDataIn, 32'd0);
    chk("abort ready", {31'd0, mem_ready}, 32'd0);
    chk("abort busy", {31'd0, mem_busy}, 32'd0);
    chk("abort mar", mar_q, 32'd0);
    #1 clear = 1'b0;
    repeat (6) tick();
    chk("no ready after abort", 32'(ready_cnt - rc), 32'd0);
    set_mar(32'h0000_0030);
    req(1'b1, 1'b0, 32'h0, 32'h55AA_55AA, 1'b0, "read 0x30 after abort");

    set_mar(32'h0000_0000);
    req(1'b0, 1'b1, 32'h7777_7777, 32'h0, 1'b0, "write word 0");
    set_mar(32'h0000_0200);
`ifdef MEM_OOR_ERR_EN
    req(1'b0, 1'b1, 32'h1111_1111, 32'h0, 1'b1, "oor write");
    req(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, "oor read");
    set_mar(32'h0000_0000);
    req(1'b1, 1'b0, 32'h0, 32'h7777_7777, 1'b0, "word 0 kept");
`else
    req(1'b0, 1'b1, 32'h1111_1111, 32'h0, 1'b0, "wrap write");
    set_mar(32'h0000_0000);
    req(1'b1, 1'b0, 32'h0, 32'h1111_1111, 1'b0, "word 0 wrapped");
`endif

    guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    chk("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
